// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory front-end.
package dmem_pkg;

  localparam int DMEM_BYTE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DRAIN,
    DONE
  } dmem_state_t;

  // Even parity: the stored bit makes the total number of ones even.
  function automatic logic even_parity(input logic [DMEM_BYTE_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port-write / single-port-read synchronous RAM with a registered read.
module dmem_ram #(
  parameter int DEPTH = 256,
  parameter int AW    = 8,
  parameter int W     = 8
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: the array and read register carry no reset so the RAM maps onto
  // block memory; the controller qualifies rdata with its own reset flags.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/dmem_controller.sv
// Data-memory front-end: host load, exclusive processor run, result drain.
// Define DMEM_PARITY_EN to store an even-parity bit with every byte and flag mismatches on par_err.
module dmem_controller
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 16
) (
  input  logic                   clock,
  input  logic                   rst_r,
  input  logic                   host_valid,
  output logic                   host_ready,
  input  logic [DMEM_BYTE_W-1:0] host_data,
  input  logic                   host_last,
  output logic                   proc_go,
  input  logic                   dm_en,
  input  logic [ADDR_W-1:0]      ar_out,
  input  logic [DMEM_BYTE_W-1:0] bus_out,
  output logic [DMEM_BYTE_W-1:0] dm_out,
  input  logic                   end_process,
  input  logic [ADDR_W-1:0]      res_base,
  input  logic [ADDR_W-1:0]      res_len,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DMEM_BYTE_W-1:0] out_data,
  output logic                   out_last,
  input  logic                   restart,
  output logic                   done,
  output logic                   ovf,
  output logic                   addr_err,
  output logic                   par_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef DMEM_PARITY_EN
  localparam int RAM_W = DMEM_BYTE_W + 1;
`else
  localparam int RAM_W = DMEM_BYTE_W;
`endif

  dmem_state_t state, state_next;

  logic                   armed;
  logic [AW-1:0]          load_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [ADDR_W-1:0]      remain;
  logic                   dm_valid;
  logic                   load_hs, load_end, drain_hs, drain_end, proc_in_range;
  logic                   ram_we;
  logic [AW-1:0]          ram_waddr, ram_raddr;
  logic [DMEM_BYTE_W-1:0] wr_byte, rd_byte;
  logic [RAM_W-1:0]       ram_wdata, ram_rdata;
  logic                   unused_res_base;

  // Only the low address bits of res_base matter since the drain wraps modulo DEPTH.
  assign unused_res_base = ^res_base;

  assign proc_in_range = (ar_out >> AW) == '0;
  assign load_hs       = (state == LOAD) && host_valid;
  assign load_end      = load_hs && (host_last || (load_ptr == AW'(DEPTH - 1)));
  assign drain_hs      = out_valid && out_ready;
  assign drain_end     = drain_hs && out_last;

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge rst_r) begin
    if (!rst_r) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_next = state;
    host_ready = 1'b0;
    proc_go    = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE:  if (armed) state_next = LOAD;
      LOAD: begin
        host_ready = 1'b1;
        if (load_end) state_next = RUN;
      end
      RUN: begin
        proc_go = 1'b1;
        if (end_process) state_next = (res_len == '0) ? DONE : DRAIN;
      end
      DRAIN: if (drain_end) state_next = DONE;
      DONE: begin
        done = 1'b1;
        if (restart) state_next = LOAD;
      end
      default: state_next = IDLE;
    endcase
  end

  // Write port: host during LOAD, processor during RUN (in-range only).
  assign ram_we    = load_hs || ((state == RUN) && dm_en && proc_in_range);
  assign ram_waddr = (state == LOAD) ? load_ptr : ar_out[AW-1:0];
  assign wr_byte   = (state == LOAD) ? host_data : bus_out;

  // Read port: drain pointer (prefetching on a handshake) or processor address.
  assign ram_raddr = (state == DRAIN) ? (drain_hs ? rd_ptr + AW'(1) : rd_ptr)
                                      : ar_out[AW-1:0];

  dmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (RAM_W)
  ) u_ram (
    .clock (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clock or negedge rst_r) begin
    if (!rst_r) begin
      armed     <= 1'b0;
      load_ptr  <= '0;
      rd_ptr    <= '0;
      remain    <= '0;
      out_valid <= 1'b0;
      dm_valid  <= 1'b0;
      ovf       <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      // IDLE lasts one full cycle after reset release before LOAD opens.
      armed <= 1'b1;
      if (load_hs) load_ptr <= load_ptr + AW'(1);
      if ((state == DONE) && restart) load_ptr <= '0;
      if ((state == RUN) && end_process) begin
        rd_ptr <= res_base[AW-1:0];
        remain <= res_len;
      end else if (drain_hs) begin
        rd_ptr <= rd_ptr + AW'(1);
        remain <= remain - ADDR_W'(1);
      end
      out_valid <= (state == DRAIN) && !drain_end;
      dm_valid  <= (state == RUN) && proc_in_range;
      if (load_hs && !host_last && (load_ptr == AW'(DEPTH - 1))) ovf <= 1'b1;
      if ((state == RUN) && !proc_in_range) addr_err <= 1'b1;
    end
  end

`ifdef DMEM_PARITY_EN
  assign ram_wdata = {even_parity(wr_byte), wr_byte};
  assign rd_byte   = ram_rdata[DMEM_BYTE_W-1:0];

  always_ff @(posedge clock or negedge rst_r) begin
    if (!rst_r) par_err <= 1'b0;
    else if ((dm_valid || out_valid) && (ram_rdata[DMEM_BYTE_W] != even_parity(rd_byte)))
      par_err <= 1'b1;
  end
`else
  assign ram_wdata = wr_byte;
  assign rd_byte   = ram_rdata;
  assign par_err   = 1'b0;
`endif

  assign dm_out   = dm_valid  ? rd_byte : '0;
  assign out_data = out_valid ? rd_byte : '0;
  assign out_last = out_valid && (remain == ADDR_W'(1));

endmodule

// File: tb/tb_dmem_controller.sv
// Randomized self-checking bench for dmem_controller against a byte-array reference model.
module tb_dmem_controller;

  localparam int DEPTH = 4;

  logic        clock;
  logic        rst_r;
  logic        host_valid, host_ready, host_last;
  logic [7:0]  host_data;
  logic        proc_go, dm_en;
  logic [15:0] ar_out;
  logic [7:0]  bus_out, dm_out;
  logic        end_process;
  logic [15:0] res_base, res_len;
  logic        out_valid, out_ready, out_last;
  logic [7:0]  out_data;
  logic        restart, done, ovf, addr_err, par_err;

  dmem_controller #(.DEPTH(DEPTH), .ADDR_W(16)) dut (
    .clock(clock), .rst_r(rst_r),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data), .host_last(host_last),
    .proc_go(proc_go), .dm_en(dm_en), .ar_out(ar_out), .bus_out(bus_out), .dm_out(dm_out),
    .end_process(end_process), .res_base(res_base), .res_len(res_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .restart(restart), .done(done), .ovf(ovf), .addr_err(addr_err), .par_err(par_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: RAM image, parity-corruption marks, load pointer, sticky flags.
  logic [7:0] ref_mem [DEPTH];
  bit         bad_par [DEPTH];
  int         m_ptr;
  bit         m_ovf, m_aerr, m_perr;
  logic [7:0] byte_q [$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] out_vec();
    return {8'h0, host_ready, proc_go, dm_out, out_valid, out_data, out_last,
            done, ovf, addr_err, par_err};
  endfunction

  task automatic reset_seq();
    rst_r = 1'b0;
    host_valid = 0; host_last = 0; host_data = 0; dm_en = 0; ar_out = 0; bus_out = 0;
    end_process = 0; res_base = 0; res_len = 0; out_ready = 0; restart = 0;
    m_ptr = 0; m_ovf = 0; m_aerr = 0; m_perr = 0;
    repeat (2) @(negedge clock);
    check("rst_outs", out_vec(), 32'h0);
    rst_r = 1'b1;
    @(negedge clock);
    check("rel_ready_c1", host_ready, 1'b0);
    @(negedge clock);
    check("rel_ready_c2", host_ready, 1'b1);
  endtask

  // Offers beats until the model leaves LOAD; last_at < 0 means no host_last.
  task automatic load_phase(input int last_at);
    int i, budget;
    bit in_load;
    logic [7:0] b;
    i = 0; budget = 60; in_load = 1'b1;
    while (in_load && budget > 0) begin
      budget--;
      check("ld_ready", host_ready, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        host_valid  = 1'b0;
        end_process = 1'($urandom_range(0, 1));
      end else begin
        if (byte_q.size() > 0) b = byte_q.pop_front();
        else                   b = 8'($urandom);
        end_process = 1'b0;
        host_valid  = 1'b1;
        host_data   = b;
        host_last   = (i == last_at);
        ref_mem[m_ptr] = b;
        bad_par[m_ptr] = 1'b0;
        if (i == last_at) in_load = 1'b0;
        else if (m_ptr == DEPTH - 1) begin
          in_load = 1'b0;
          m_ovf   = 1'b1;
        end
        m_ptr++; i++;
      end
      @(negedge clock);
    end
    host_valid = 0; host_last = 0; end_process = 0;
    check("ld_finished", in_load, 1'b0);
    check("ld_go", proc_go, 1'b1);
    check("ld_ready_off", host_ready, 1'b0);
    check("ld_ovf", ovf, m_ovf);
    // A beat offered after LOAD closes must be refused.
    host_valid = 1'b1; host_data = 8'($urandom);
    @(negedge clock);
    host_valid = 1'b0;
    check("xtra_go", proc_go, 1'b1);
  endtask

  task automatic proc_op(input bit we, input int addr, input logic [7:0] d);
    logic [7:0] exp;
    dm_en = we; ar_out = 16'(addr); bus_out = d; restart = 1'($urandom_range(0, 1));
    exp = (addr < DEPTH) ? ref_mem[addr] : 8'h00;
    if (addr >= DEPTH) m_aerr = 1'b1;
    else begin
      if (bad_par[addr]) m_perr = 1'b1;
      if (we) begin
        ref_mem[addr] = d;
        bad_par[addr] = 1'b0;
      end
    end
    @(negedge clock);
    check("dm_out", dm_out, exp);
    check("run_go", proc_go, 1'b1);
    check("addr_err", addr_err, m_aerr);
    dm_en = 0; ar_out = 0; restart = 0;
  endtask

  // abort_at > 0 asserts reset mid-cycle on that drain cycle.
  task automatic drain_phase(input int base, input int len, input int abort_at);
    int k, cyc, a;
    k = 0; cyc = 0;
    end_process = 1'b1; res_base = 16'(base); res_len = 16'(len);
    @(negedge clock);
    end_process = 1'b0; res_base = 16'($urandom); res_len = 16'($urandom);
    check("dr_go_off", proc_go, 1'b0);
    check("dr_entry_valid", out_valid, 1'b0);
    if (len == 0) begin
      check("zl_done", done, 1'b1);
      repeat (3) begin
        @(negedge clock);
        check("zl_valid", out_valid, 1'b0);
      end
    end else begin
      while (k < len && cyc < 200) begin
        @(negedge clock);
        cyc++;
        if (cyc == abort_at) begin
          #2 rst_r = 1'b0;
          #1 check("abort_outs", out_vec(), 32'h0);
          out_ready = 1'b0;
          return;
        end
        a = (base + k) % DEPTH;
        if (bad_par[a]) m_perr = 1'b1;
        check("dr_valid", out_valid, 1'b1);
        check("dr_data", out_data, ref_mem[a]);
        check("dr_last", out_last, (k == len - 1));
        out_ready = 1'($urandom_range(0, 1));
        if (out_ready) k++;
      end
      check("dr_beats", k, len);
      @(negedge clock);
      out_ready = 1'b0;
      check("dr_valid_off", out_valid, 1'b0);
      check("dr_done", done, 1'b1);
    end
    check("flags", {ovf, addr_err, par_err}, {m_ovf, m_aerr, m_perr});
  endtask

  // In DONE: stray dm_en / end_process are ignored, then restart reopens LOAD.
  task automatic done_restart();
    dm_en = 1'b1; ar_out = 16'($urandom_range(0, DEPTH - 1)); bus_out = 8'($urandom);
    end_process = 1'b1;
    @(negedge clock);
    check("done_hold", done, 1'b1);
    check("done_go", proc_go, 1'b0);
    dm_en = 0; ar_out = 0; end_process = 0; restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    m_ptr = 0;
    check("rs_ready", host_ready, 1'b1);
    check("rs_done", done, 1'b0);
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) proc_op(1'b0, a, 8'h00);
  endtask

  task automatic episode();
    int last_at, addr;
    last_at = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 4));
    load_phase(last_at);
    repeat ($urandom_range(2, 8)) begin
      addr = ($urandom_range(0, 9) == 0) ? 300 : int'($urandom_range(0, DEPTH + 1));
      proc_op(1'($urandom_range(0, 1)), addr, 8'($urandom));
    end
    drain_phase(int'($urandom_range(0, 65535)), int'($urandom_range(0, 9)), -1);
    done_restart();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_r = 1'b1;
    for (int a = 0; a < DEPTH; a++) bad_par[a] = 1'b0;
    #2;
    reset_seq();

    // Directed load of four bytes, last beat at the final address.
    byte_q = {8'h11, 8'h22, 8'h33, 8'h44};
    load_phase(3);
    read_all();
    proc_op(1'b1, 2, 8'hA5);
    proc_op(1'b0, 2, 8'h00);
    check("dir_a5", dm_out, 8'hA5);
    proc_op(1'b0, 300, 8'h00);
    check("dir_oor_data", dm_out, 8'h00);
    check("dir_oor_flag", addr_err, 1'b1);
    drain_phase(1, 3, -1);
    done_restart();

    // Zero-length drain.
    load_phase(0);
    drain_phase(0, 0, -1);
    done_restart();

    // Overflow: no host_last, DEPTH beats fill the RAM and the next is refused.
    load_phase(-1);
    read_all();
    drain_phase(0, 4, -1);
    done_restart();

`ifdef DMEM_PARITY_EN
    load_phase(1);
    dut.u_ram.mem[1] = dut.u_ram.mem[1] ^ 9'h001;
    ref_mem[1] = ref_mem[1] ^ 8'h01;
    bad_par[1] = 1'b1;
    proc_op(1'b0, 1, 8'h00);
    @(negedge clock);
    check("par_err", par_err, 1'b1);
    drain_phase(0, 4, -1);
    done_restart();
`endif

    repeat (25) episode();

    // Reset in the middle of a drain, then resume normal operation.
    load_phase(2);
    drain_phase(2, 6, 3);
    reset_seq();
    episode();
    episode();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
